// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
// Carries ID/EX operand info in and the PC / pipeline-register controls out.
interface hazard_control_unit_if;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd_addr;
    logic        ex_mem_read;
    logic        ex_pc_src;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        busy;
    logic [31:0] bubble_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_rd_addr, ex_mem_read, ex_pc_src,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, busy, bubble_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_rd_addr, ex_mem_read, ex_pc_src,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, busy, bubble_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush control for the 5-stage pipeline, with
// multi-cycle stretching and a saturating bubble counter.
module hazard_control_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned CNT_W             = 4
) (
    input logic                  clk,
    input logic                  reset,
    hazard_control_unit_if.slave hz
);
    typedef enum logic [1:0] {StIdle, StLoadStall, StFlush} state_e;

    localparam logic [CNT_W-1:0] StallLast = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FlushLast = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      bubble_q;
    logic             lu;

    assign lu = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
                ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                 (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.ex_rd_addr)));

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        hz.pc_write_en    = 1'b1;
        hz.if_id_write_en = 1'b1;
        hz.if_id_flush    = 1'b0;
        hz.id_ex_flush    = 1'b0;

        // A taken branch wins in every state: the ID instruction is dead anyway.
        if (hz.ex_pc_src) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = CntOne;
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (lu) begin
                        hz.pc_write_en    = 1'b0;
                        hz.if_id_write_en = 1'b0;
                        hz.id_ex_flush    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = StLoadStall;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StLoadStall: begin
                    hz.pc_write_en    = 1'b0;
                    hz.if_id_write_en = 1'b0;
                    hz.id_ex_flush    = 1'b1;
                    if (cnt_q == StallLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StFlush: begin
                    hz.if_id_flush = 1'b1;
                    hz.id_ex_flush = 1'b1;
                    if (cnt_q == FlushLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        if (reset) begin
            hz.pc_write_en    = 1'b0;
            hz.if_id_write_en = 1'b0;
            hz.if_id_flush    = 1'b1;
            hz.id_ex_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bubble_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hz.id_ex_flush && (bubble_q != 32'hFFFF_FFFF)) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign hz.busy         = (state_q != StIdle);
    assign hz.bubble_count = bubble_q;
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Produces the stall and flush controls consumed by the PC register, IF_ID and ID_EX pipeline registers of the 5-stage RISC-V core.
- Detects load-use hazards between the instruction in ID and a load in EX, and control hazards when EX resolves a taken branch or jump.
- A small FSM stretches each event over a parameterised number of cycles.
- A saturating counter records total bubble cycles for performance monitoring.

Parameters:
- LOAD_STALL_CYCLES, 1: bubble cycles inserted per load-use hazard (legal range 1..15).
- FLUSH_CYCLES, 1: cycles of IF_ID/ID_EX flush per taken branch (legal range 1..15).
- CNT_W, 4: width of the internal cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_rs1_addr  input  5  rs1 field of the instruction in ID.
- id_rs2_addr  input  5  rs2 field of the instruction in ID.
- id_uses_rs1  input  1  the ID instruction reads rs1.
- id_uses_rs2  input  1  the ID instruction reads rs2.
- ex_rd_addr  input  5  rd of the instruction in EX (the ID_EX rd output).
- ex_mem_read  input  1  the instruction in EX is a load.
- ex_pc_src  input  1  EX resolved a taken branch or jump this cycle.
- pc_write_en  output  1  1 = PC updates; 0 = PC holds.
- if_id_write_en  output  1  1 = IF_ID captures; 0 = IF_ID holds.
- if_id_flush  output  1  IF_ID is loaded with a NOP.
- id_ex_flush  output  1  ID_EX control fields are zeroed (bubble).
- busy  output  1  FSM is not in IDLE.
- bubble_count  output  32  total cycles in which id_ex_flush was 1; saturates at 0xFFFFFFFF.

Behaviour:
- FSM states: IDLE, LOAD_STALL, FLUSH. The state, the counter cnt and bubble_count are registered. All other outputs are combinational from state and current inputs; same-cycle response is required.
- Load-use condition: lu = ex_mem_read && ex_rd_addr != 0 && ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr)).
- Normal outputs: pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_flush=0.
- Stall outputs: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_flush=1.
- Flush outputs: pc_write_en=1 (PC takes the target), if_id_write_en=1, if_id_flush=1, id_ex_flush=1.
- Priority in every state: ex_pc_src > lu > state continuation. A branch in EX kills the ID instruction, so the stall is dropped.
- IDLE:
  - If ex_pc_src: drive flush outputs. If FLUSH_CYCLES>1, go to FLUSH with cnt=1; otherwise stay in IDLE.
  - Else if lu: drive stall outputs. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=1; otherwise stay in IDLE.
  - Else: drive normal outputs.
- LOAD_STALL:
  - Drive stall outputs, cnt++.
  - When cnt == LOAD_STALL_CYCLES-1 in this cycle, return to IDLE with cnt=0.
  - ex_pc_src=1 here aborts to the flush path with cnt restarting at 1 (or IDLE if FLUSH_CYCLES=1).
- FLUSH:
  - Drive flush outputs, cnt++.
  - When cnt == FLUSH_CYCLES-1, return to IDLE.
  - A new ex_pc_src in FLUSH restarts cnt at 1.
  - lu is ignored in FLUSH.
- busy = (state != IDLE).
- bubble_count increments by 1 on each rising edge where id_ex_flush was 1 in the preceding cycle. It holds at 0xFFFFFFFF once reached, with no wrap.
- Reset asserted (asynchronous, at any time including mid-stall or mid-flush):
  - state=IDLE, cnt=0, bubble_count=0.
  - Outputs forced while reset=1: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_flush=1.
  - Flushes asserted under reset do not count toward bubble_count.
  - First edge after deassertion behaves as IDLE.
- ex_rd_addr=0 (x0) never causes a stall. A match on a register the ID instruction does not use never stalls.

Test Plan:
- Load-use on rs1: ex_mem_read=1, ex_rd_addr=5, id_rs1_addr=5, id_uses_rs1=1, defaults -> same cycle pc_write_en=0, if_id_write_en=0, id_ex_flush=1. Next cycle with ex_mem_read=0 -> normal outputs; bubble_count=1.
- x0 and unused operand: ex_rd_addr=0 with matching rs1 -> normal outputs. ex_rd_addr=7, id_rs2_addr=7, id_uses_rs2=0 -> normal outputs.
- LOAD_STALL_CYCLES=3: single lu pulse -> stall outputs for exactly 3 cycles, busy=1 for cycles 1-2 after detection, then normal; bubble_count=3.
- Branch vs. load-use same cycle: ex_pc_src=1 and lu=1 -> flush outputs with pc_write_en=1. With FLUSH_CYCLES=2: flush outputs for 2 cycles, state FLUSH then IDLE.
- Branch during LOAD_STALL (LOAD_STALL_CYCLES=3): ex_pc_src=1 in second stall cycle -> immediate flush outputs, stall abandoned.
- Reset mid-FLUSH: assert reset between edges -> outputs change immediately to the reset values, busy=0, bubble_count=0. After release with quiet inputs -> normal outputs.
